game_session_ctrl: RTL and testbench
====================================

# game_session_ctrl

Parametrised game-session controller: next generation of the single-life pregame/game/over FSM. It adds a lives budget, pause/resume, a timed respawn freeze, a saturating score counter and a high-score register. It sits between the input front end (buttons, collision detector, score-event logic) and the rendering/physics blocks, all clocked from CLOCK_50. Outputs are registered and drive the enable and status of the rest of the game.

## Interface
Parameters:
- LIVES, 3: lives granted at game start (1..15).
- LIVES_W, 4: width of lives counter.
- SCORE_W, 16: width of score and high-score registers.
- RESPAWN_FRAMES, 60: frame_tick pulses spent in RESPAWN after a non-fatal collision (0 allowed).
- RESP_W, 8: width of respawn counter; must hold RESPAWN_FRAMES.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level button; acted on at rising edge only.
- pause  in  1  level button; acted on at rising edge only.
- collision  in  1  level; fatal-hit indication, sampled every cycle in PLAY.
- point  in  1  one-cycle score event.
- frame_tick  in  1  one-cycle pulse per video frame.
- gameon  out  1  high only in PLAY.
- paused  out  1  high only in PAUSE.
- respawning  out  1  high only in RESPAWN.
- state  out  3  current state code.
- lives  out  LIVES_W  lives remaining.
- score  out  SCORE_W  current score.
- hiscore  out  SCORE_W  best final score since reset.
- game_over  out  1  one-cycle pulse on entry to OVER.

## Operation
- States: IDLE=0, PLAY=1, PAUSE=2, RESPAWN=3, OVER=4. Codes 5-7 are illegal and go to IDLE on the next edge.
- start_rise = start & ~start_q; pause_rise likewise. start_q and pause_q are registered copies of the inputs and reset to 0.
- IDLE, OVER: on start_rise go to PLAY, load lives=LIVES, score=0. Other inputs ignored.
- PLAY, priority collision > pause_rise > point:
  - collision with lives>1: decrement lives, clear respawn counter, go to RESPAWN.
  - collision with lives==1: lives=0, go to OVER, pulse game_over. If score>hiscore, hiscore=score.
  - pause_rise: go to PAUSE.
  - point: score+1, saturating at 2^SCORE_W-1. Ignored on a collision cycle. Counted on a pause_rise cycle.
- PAUSE: pause_rise returns to PLAY. Collision, point, start and frame_tick are ignored.
- RESPAWN: counter increments on each frame_tick. When counter==RESPAWN_FRAMES, go to PLAY. If RESPAWN_FRAMES=0, leave on the next cycle. Collision, point and pause are ignored.
- start_rise in PLAY, PAUSE or RESPAWN is ignored; there is no mid-game restart.
- Reset values: state=IDLE, gameon=0, paused=0, respawning=0, lives=0, score=0, hiscore=0, game_over=0, counters=0.

## Timing
- Status outputs are registered from next state, so each is valid the same edge the state changes. Input sampled at edge n gives state and outputs updated at edge n.
- start_rise is visible one cycle after the input's first high sample that follows a low sample. The button must be low for at least 1 cycle between presses.
- game_over is high for exactly the first cycle in OVER.
- The hiscore update and the OVER entry happen on the same edge.
- Respawn duration is RESPAWN_FRAMES frame_ticks plus 1 cycle.
- Asserting reset asynchronously forces all reset values regardless of state. Deassertion is synchronised externally.

## Structure
- Package game_pkg holds the state localparams (IDLE..OVER) and STATE_W=3. It is shared with renderer and HUD blocks.
- Sub-module edge_rise (CLOCK_50, reset, d -> rise) is instantiated twice, for start and pause.
- Single always block for state and counters; outputs are decoded from the next-state register.

## Test plan
- Reset then start pulse → state=1, gameon=1, lives=3, score=0. Holding start high does not re-trigger.
- In PLAY, 5 point pulses, then collision → score=5, lives=2, respawning=1. After 60 frame_ticks, +1 cycle → state=1.
- Three collisions (respawn windows elapsed) → OVER, game_over pulses for 1 cycle, hiscore=score. Next game scoring lower leaves hiscore unchanged.
- pause rise in PLAY → paused=1. Points and collisions ignored. A second pause rise → PLAY with score and lives unchanged.
- Collision and point on the same cycle → score unchanged, lives decremented. SCORE_W=4 with 20 points → score=15.
- reset driven low mid-RESPAWN → all outputs at reset values immediately, including hiscore=0. RESPAWN_FRAMES=0 build → RESPAWN lasts 1 cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-state encoding for the session controller, renderer and HUD.
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        PAUSE   = 3'd2,
        RESPAWN = 3'd3,
        OVER    = 3'd4
    } state_e;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for level buttons.
// The rise flag is registered, so the controller sees it one cycle after the first high sample.
module edge_rise (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q_r;
    logic rise_r;

    // Keep the previous sample and register the low-to-high detection.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            d_q_r  <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            d_q_r  <= d;
            rise_r <= d & ~d_q_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/game_session_ctrl.sv
// Game-session controller: lives budget, pause/resume, timed respawn freeze,
// saturating score and high-score register. Status outputs come from next state.
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int LIVES_W        = 4,
    parameter int SCORE_W        = 16,
    parameter int RESPAWN_FRAMES = 60,
    parameter int RESP_W         = 8
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               pause,
    input  logic               collision,
    input  logic               point,
    input  logic               frame_tick,
    output logic               gameon,
    output logic               paused,
    output logic               respawning,
    output logic [STATE_W-1:0] state,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hiscore,
    output logic               game_over
);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [LIVES_W-1:0] lives_r;
    logic [LIVES_W-1:0] lives_nxt_s;
    logic [SCORE_W-1:0] score_r;
    logic [SCORE_W-1:0] score_nxt_s;
    logic [SCORE_W-1:0] hiscore_r;
    logic [SCORE_W-1:0] hiscore_nxt_s;
    logic [RESP_W-1:0]  resp_cnt_r;
    logic [RESP_W-1:0]  resp_cnt_nxt_s;
    logic               gameon_r;
    logic               paused_r;
    logic               respawning_r;
    logic               game_over_r;
    logic               start_rise_s;
    logic               pause_rise_s;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (v == {SCORE_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + SCORE_W'(1);
        end
    endfunction

    edge_rise u_start_rise (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d        (start),
        .rise     (start_rise_s)
    );

    edge_rise u_pause_rise (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .d        (pause),
        .rise     (pause_rise_s)
    );

    // Next-state, counter and score decisions for the session FSM.
    always_comb begin
        state_nxt_s    = state_r;
        lives_nxt_s    = lives_r;
        score_nxt_s    = score_r;
        hiscore_nxt_s  = hiscore_r;
        resp_cnt_nxt_s = resp_cnt_r;
        case (state_r)
            IDLE, OVER: begin
                if (start_rise_s) begin
                    state_nxt_s = PLAY;
                    lives_nxt_s = LIVES_W'(LIVES);
                    score_nxt_s = {SCORE_W{1'b0}};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            PLAY: begin
                // Collision wins over pause and point; a lost point on that cycle is intended.
                if (collision) begin
                    if (lives_r > LIVES_W'(1)) begin
                        lives_nxt_s    = lives_r - LIVES_W'(1);
                        resp_cnt_nxt_s = {RESP_W{1'b0}};
                        state_nxt_s    = RESPAWN;
                    end else begin
                        lives_nxt_s = {LIVES_W{1'b0}};
                        state_nxt_s = OVER;
                        if (score_r > hiscore_r) begin
                            hiscore_nxt_s = score_r;
                        end else begin
                            hiscore_nxt_s = hiscore_r;
                        end
                    end
                end else begin
                    if (point) begin
                        score_nxt_s = sat_inc(score_r);
                    end else begin
                        score_nxt_s = score_r;
                    end
                    if (pause_rise_s) begin
                        state_nxt_s = PAUSE;
                    end else begin
                        state_nxt_s = PLAY;
                    end
                end
            end
            PAUSE: begin
                if (pause_rise_s) begin
                    state_nxt_s = PLAY;
                end else begin
                    state_nxt_s = PAUSE;
                end
            end
            RESPAWN: begin
                if (resp_cnt_r == RESP_W'(RESPAWN_FRAMES)) begin
                    state_nxt_s = PLAY;
                end else if (frame_tick) begin
                    resp_cnt_nxt_s = resp_cnt_r + RESP_W'(1);
                end else begin
                    resp_cnt_nxt_s = resp_cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs decoded from the next state.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            lives_r      <= {LIVES_W{1'b0}};
            score_r      <= {SCORE_W{1'b0}};
            hiscore_r    <= {SCORE_W{1'b0}};
            resp_cnt_r   <= {RESP_W{1'b0}};
            gameon_r     <= 1'b0;
            paused_r     <= 1'b0;
            respawning_r <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            lives_r      <= lives_nxt_s;
            score_r      <= score_nxt_s;
            hiscore_r    <= hiscore_nxt_s;
            resp_cnt_r   <= resp_cnt_nxt_s;
            gameon_r     <= (state_nxt_s == PLAY);
            paused_r     <= (state_nxt_s == PAUSE);
            respawning_r <= (state_nxt_s == RESPAWN);
            game_over_r  <= (state_nxt_s == OVER) && (state_r != OVER);
        end
    end

    assign state      = state_r;
    assign lives      = lives_r;
    assign score      = score_r;
    assign hiscore    = hiscore_r;
    assign gameon     = gameon_r;
    assign paused     = paused_r;
    assign respawning = respawning_r;
    assign game_over  = game_over_r;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench: two controller builds driven by shared stimulus, each checked
// every cycle against a rule-level reference model.
module tb_game_session_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       collision = 1'b0;
    logic       point = 1'b0;
    logic       frame_tick = 1'b0;

    logic       a_gameon, a_paused, a_respawning, a_game_over;
    logic [2:0] a_state;
    logic [3:0] a_lives;
    logic [15:0] a_score, a_hiscore;
    logic       b_gameon, b_paused, b_respawning, b_game_over;
    logic [2:0] b_state;
    logic [3:0] b_lives;
    logic [3:0] b_score, b_hiscore;

    int errors = 0;
    int checks = 0;

    localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSE = 2, S_RESP = 3, S_OVER = 4;

    int c_lives [2] = '{3, 2};
    int c_max   [2] = '{65535, 15};
    int c_rf    [2] = '{60, 0};

    int m_st [2];
    int m_lv [2];
    int m_sc [2];
    int m_hs [2];
    int m_rc [2];
    bit m_go [2];
    bit m_sr, m_pr, m_sp, m_pp;

    typedef struct {
        int k;
        int st;
        int lv;
        int sc;
        int hs;
        bit go;
    } exp_t;

    exp_t q[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    game_session_ctrl #(.LIVES(3), .LIVES_W(4), .SCORE_W(16), .RESPAWN_FRAMES(60), .RESP_W(8)) u_a (
        .CLOCK_50 (CLOCK_50), .reset (reset), .start (start), .pause (pause),
        .collision (collision), .point (point), .frame_tick (frame_tick),
        .gameon (a_gameon), .paused (a_paused), .respawning (a_respawning), .state (a_state),
        .lives (a_lives), .score (a_score), .hiscore (a_hiscore), .game_over (a_game_over)
    );

    game_session_ctrl #(.LIVES(2), .LIVES_W(4), .SCORE_W(4), .RESPAWN_FRAMES(0), .RESP_W(8)) u_b (
        .CLOCK_50 (CLOCK_50), .reset (reset), .start (start), .pause (pause),
        .collision (collision), .point (point), .frame_tick (frame_tick),
        .gameon (b_gameon), .paused (b_paused), .respawning (b_respawning), .state (b_state),
        .lives (b_lives), .score (b_score), .hiscore (b_hiscore), .game_over (b_game_over)
    );

    // Reference model: apply one clock edge of game rules for build k.
    function automatic void model_one(input int k, input bit sr, input bit pr);
        m_go[k] = 1'b0;
        case (m_st[k])
            S_IDLE, S_OVER: if (sr) begin m_st[k] = S_PLAY; m_lv[k] = c_lives[k]; m_sc[k] = 0; end
            S_PLAY: begin
                if (collision) begin
                    if (m_lv[k] > 1) begin
                        m_lv[k] = m_lv[k] - 1; m_rc[k] = 0; m_st[k] = S_RESP;
                    end else begin
                        m_lv[k] = 0; m_st[k] = S_OVER; m_go[k] = 1'b1;
                        if (m_sc[k] > m_hs[k]) m_hs[k] = m_sc[k];
                    end
                end else begin
                    if (point && m_sc[k] < c_max[k]) m_sc[k] = m_sc[k] + 1;
                    if (pr) m_st[k] = S_PAUSE;
                end
            end
            S_PAUSE: if (pr) m_st[k] = S_PLAY;
            S_RESP: begin
                if (m_rc[k] == c_rf[k]) m_st[k] = S_PLAY;
                else if (frame_tick) m_rc[k] = m_rc[k] + 1;
            end
            default: m_st[k] = S_IDLE;
        endcase
    endfunction

    // Advance the model by one edge using the inputs just driven and queue expectations.
    function automatic void model_step();
        bit sr, pr;
        sr = m_sr;
        pr = m_pr;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_st[k] = S_IDLE; m_lv[k] = 0; m_sc[k] = 0; m_hs[k] = 0; m_rc[k] = 0; m_go[k] = 1'b0;
            end else begin
                model_one(k, sr, pr);
            end
        end
        if (!reset) begin
            m_sr = 1'b0; m_pr = 1'b0; m_sp = 1'b0; m_pp = 1'b0;
        end else begin
            m_sr = start && !m_sp;
            m_pr = pause && !m_pp;
            m_sp = start;
            m_pp = pause;
        end
        for (int k = 0; k < 2; k++) begin
            q.push_back('{k, m_st[k], m_lv[k], m_sc[k], m_hs[k], m_go[k]});
        end
    endfunction

    task automatic compare(input exp_t e);
        int st, lv, sc, hs;
        bit on, pa, rs, go;
        if (e.k == 0) begin
            st = a_state; lv = a_lives; sc = a_score; hs = a_hiscore;
            on = a_gameon; pa = a_paused; rs = a_respawning; go = a_game_over;
        end else begin
            st = b_state; lv = b_lives; sc = b_score; hs = b_hiscore;
            on = b_gameon; pa = b_paused; rs = b_respawning; go = b_game_over;
        end
        checks++;
        if (st != e.st || lv != e.lv || sc != e.sc || hs != e.hs || go != e.go ||
            on != (e.st == S_PLAY) || pa != (e.st == S_PAUSE) || rs != (e.st == S_RESP)) begin
            errors++;
            $display("FAIL dut%0d_outputs t=%0t: got st=%0d lv=%0d sc=%0d hs=%0d go=%0d on=%0d pa=%0d rs=%0d, want st=%0d lv=%0d sc=%0d hs=%0d go=%0d",
                     e.k, $time, st, lv, sc, hs, go, on, pa, rs, e.st, e.lv, e.sc, e.hs, e.go);
        end
    endtask

    // Monitor: after each rising edge, pop and check everything queued for it.
    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            while (q.size() > 0) compare(q.pop_front());
        end
    end

    task automatic cyc(input bit s, input bit p, input bit c, input bit pt, input bit ft, input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            start = s; pause = p; collision = c; point = pt; frame_tick = ft;
            model_step();
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input int n);
        @(negedge CLOCK_50);
        reset = 1'b0;
        start = 1'b0; pause = 1'b0; collision = 1'b0; point = 1'b0; frame_tick = 1'b0;
        model_step();
        #1;
        checks++;
        if (a_state != 3'd0 || a_lives != 4'd0 || a_score != 16'd0 || a_hiscore != 16'd0 ||
            a_gameon || a_paused || a_respawning || a_game_over ||
            b_state != 3'd0 || b_lives != 4'd0 || b_score != 4'd0 || b_hiscore != 4'd0 ||
            b_gameon || b_paused || b_respawning || b_game_over) begin
            errors++;
            $display("FAIL async_reset: got a_st=%0d a_lv=%0d a_sc=%0d a_hs=%0d b_st=%0d b_hs=%0d, want all 0",
                     a_state, a_lives, a_score, a_hiscore, b_state, b_hiscore);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n - 1);
        @(negedge CLOCK_50);
        reset = 1'b1;
        model_step();
    endtask

    task automatic press_start();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    endtask

    task automatic press_pause();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        end
    endtask

    task automatic points(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        end
    endtask

    initial begin
        m_sr = 1'b0; m_pr = 1'b0; m_sp = 1'b0; m_pp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_lv[k] = 0; m_sc[k] = 0; m_hs[k] = 0; m_rc[k] = 0; m_go[k] = 1'b0;
        end
        do_reset(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        // Held start must trigger only once.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        points(5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        ticks(62);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        // Pause: points and collisions ignored, then resume.
        press_pause();
        points(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        press_pause();
        points(20);
        // Collision and point on the same cycle.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        ticks(62);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        // Lower-scoring game leaves hiscore alone; start in OVER restarts.
        press_start();
        points(3);
        repeat (3) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
            ticks(62);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        // Reset in the middle of a respawn freeze.
        press_start();
        points(2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        ticks(5);
        do_reset(2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 1999) == 0) begin
                do_reset(2);
            end else begin
                cyc($urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0, 1);
            end
        end
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
